reg_wr_arbiter: RTL

Shares the write port of a single 16-bit enabled storage register between up to four requesters using round-robin arbitration. Each requester presents a data word and holds a request; the arbiter grants one requester at a time, latches its word, performs exactly one enabled write, and returns a one-cycle acknowledge. It sits between the register-file clients and the 16-bit register and owns its `ena`/`d` sequencing, so clients never drive the register directly.

---
 rtl/reg_wr_arbiter_pkg.sv | 13 +
 rtl/reg_wr_arbiter_pick.sv | 27 ++
 rtl/reg_wr_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/reg_wr_arbiter_pkg.sv
// Shared defaults and FSM encoding for the round-robin register write arbiter.
package reg_wr_arbiter_pkg;

  localparam int unsigned RW_N_DEF     = 4;
  localparam int unsigned RW_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    ACK   = 2'b10
  } rw_state_e;

endpackage

// File: rtl/reg_wr_arbiter_pick.sv
// Combinational round-robin picker: first set request scanning from last+1 modulo N.
module rr_arb_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] win
);

  int unsigned w_idx;

  always_comb begin
    valid = 1'b0;
    win   = '0;
    w_idx = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      w_idx = (32'(last) + i) % N;
      if (!valid && req[w_idx]) begin
        valid = 1'b1;
        win   = IW'(w_idx);
      end
    end
  end

endmodule

// File: rtl/reg_wr_arbiter.sv
// Round-robin arbiter owning the write port of one enabled storage register.
module reg_wr_arbiter
  import reg_wr_arbiter_pkg::*;
#(
  parameter int unsigned N     = RW_N_DEF,
  parameter int unsigned WIDTH = RW_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           req,
  input  logic [N*WIDTH-1:0]     data,
  output logic [N-1:0]           gnt,
  output logic [N-1:0]           ack,
  output logic                   ena,
  output logic [WIDTH-1:0]       d,
  output logic [WIDTH-1:0]       q,
  output logic [$clog2(N)-1:0]   owner,
  output logic                   busy
);

  localparam int unsigned IW = $clog2(N);

  rw_state_e        r_state, w_state_nxt;
  logic [N-1:0]     r_gnt, w_gnt_nxt;
  logic [N-1:0]     r_ack, w_ack_nxt;
  logic             r_ena, w_ena_nxt;
  logic [WIDTH-1:0] r_d, w_d_nxt;
  logic [WIDTH-1:0] r_q, w_q_nxt;
  logic [IW-1:0]    r_owner, w_owner_nxt;
  logic [IW-1:0]    r_last, w_last_nxt;
  logic             r_busy, w_busy_nxt;
  logic             w_valid;
  logic [IW-1:0]    w_win;

  rr_arb_pick #(.N(N), .IW(IW)) u_pick (
    .req   (req),
    .last  (r_last),
    .valid (w_valid),
    .win   (w_win)
  );

  // State and all outputs registered together; r_last doubles as the current winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_ack   <= '0;
      r_ena   <= 1'b0;
      r_d     <= '0;
      r_q     <= '0;
      r_owner <= '0;
      r_last  <= IW'(N - 1);
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_ack   <= w_ack_nxt;
      r_ena   <= w_ena_nxt;
      r_d     <= w_d_nxt;
      r_q     <= w_q_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_ack_nxt   = '0;
    w_ena_nxt   = 1'b0;
    w_d_nxt     = r_d;
    w_q_nxt     = r_q;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    unique case (r_state)
      IDLE: begin
        w_gnt_nxt = '0;
        w_d_nxt   = '0;
        if (w_valid) begin
          w_gnt_nxt   = N'(1) << w_win;
          w_d_nxt     = data[32'(w_win)*WIDTH +: WIDTH];
          w_ena_nxt   = 1'b1;
          w_last_nxt  = w_win;
          w_state_nxt = WRITE;
        end
      end
      WRITE: begin
        w_q_nxt     = r_d;
        w_owner_nxt = r_last;
        w_ack_nxt   = r_gnt;
        w_state_nxt = ACK;
      end
      ACK: begin
        w_gnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_gnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  assign gnt   = r_gnt;
  assign ack   = r_ack;
  assign ena   = r_ena;
  assign d     = r_d;
  assign q     = r_q;
  assign owner = r_owner;
  assign busy  = r_busy;

endmodule
